// File: rtl/fdiv_seq.sv
// Iterative single-precision divider y = x1 / x2 with a restoring radix-2^BITS_PER_CYCLE core.
// Define FDIV_ROUND_EN to build round-to-nearest-even in NORM; otherwise the quotient is truncated.
module fdiv_seq #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y
);

  localparam logic [4:0] CNT_INIT = 5'(26 / BITS_PER_CYCLE - 1);

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

  state_t      state_reg, state_next;
  logic        s_reg;
  logic [7:0]  e1_reg, e2_reg;
  logic [25:0] rem_reg, rem_next;
  logic [23:0] d_reg;
  logic [25:0] q_reg, q_next;
  logic [4:0]  cnt_reg;
  logic        z1_reg, z2_reg;
  logic [31:0] y_reg, y_next;

  logic signed [9:0] exp_base, exp_fin;
  logic [22:0]       mant_trunc, mant_fin;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (in_valid)       state_next = DIV;
      DIV:  if (cnt_reg == 5'd0) state_next = NORM;
      NORM:                     state_next = DONE;
      DONE: if (out_ready)      state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign y         = y_reg;

  // BITS_PER_CYCLE restoring steps chained combinationally; quotient bits shift in at the LSB.
  always_comb begin
    rem_next = rem_reg;
    q_next   = q_reg;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (rem_next >= {2'b00, d_reg}) begin
        rem_next = rem_next - {2'b00, d_reg};
        q_next   = {q_next[24:0], 1'b1};
      end else begin
        q_next   = {q_next[24:0], 1'b0};
      end
      rem_next = {rem_next[24:0], 1'b0};
    end
  end

  always_comb begin
    exp_base   = 10'($signed({2'b00, e1_reg}) - $signed({2'b00, e2_reg}) + 10'sd127
                     - $signed({9'd0, ~q_reg[25]}));
    mant_trunc = q_reg[25] ? q_reg[24:2] : q_reg[23:1];
`ifdef FDIV_ROUND_EN
    begin
      logic        guard, sticky;
      logic [23:0] mant_sum;
      guard    = q_reg[25] ? q_reg[1] : q_reg[0];
      // rem_reg holds twice the true remainder, so its zero test is unaffected.
      sticky   = (q_reg[25] & q_reg[0]) | (rem_reg != 26'd0);
      mant_sum = {1'b0, mant_trunc} + 24'(guard && (sticky || mant_trunc[0]));
      mant_fin = mant_sum[22:0];
      exp_fin  = exp_base + $signed({9'd0, mant_sum[23]});
    end
`else
    mant_fin = mant_trunc;
    exp_fin  = exp_base;
`endif
    if (z2_reg)
      y_next = {s_reg, 8'hFF, 23'd0};
    else if (z1_reg)
      y_next = {s_reg, 31'd0};
    else if (exp_base <= 10'sd0)
      y_next = {s_reg, 31'd0};
    else if (exp_fin >= 10'sd255)
      y_next = {s_reg, 8'hFF, 23'd0};
    else
      y_next = {s_reg, exp_fin[7:0], mant_fin};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_reg   <= 1'b0;
      e1_reg  <= 8'd0;
      e2_reg  <= 8'd0;
      rem_reg <= 26'd0;
      d_reg   <= 24'd0;
      q_reg   <= 26'd0;
      cnt_reg <= 5'd0;
      z1_reg  <= 1'b0;
      z2_reg  <= 1'b0;
      y_reg   <= 32'd0;
    end else begin
      case (state_reg)
        IDLE: if (in_valid) begin
          s_reg   <= x1[31] ^ x2[31];
          e1_reg  <= x1[30:23];
          e2_reg  <= x2[30:23];
          rem_reg <= {2'b01, x1[22:0]};
          d_reg   <= {1'b1, x2[22:0]};
          q_reg   <= 26'd0;
          cnt_reg <= CNT_INIT;
          z1_reg  <= (x1[30:23] == 8'd0);
          z2_reg  <= (x2[30:23] == 8'd0);
        end
        DIV: begin
          rem_reg <= rem_next;
          q_reg   <= q_next;
          if (cnt_reg != 5'd0) cnt_reg <= cnt_reg - 5'd1;
        end
        NORM: y_reg <= y_next;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fdiv_seq.sv
// Directed self-checking bench for fdiv_seq (B=1 main instance, B=2 instance for latency).
module tb_fdiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] x1, x2, y;
  logic        in_valid_b2, in_ready_b2, out_valid_b2, out_ready_b2;
  logic [31:0] x1_b2, x2_b2, y_b2;

  int n_tests = 0;
  int n_fail  = 0;

  localparam int LAT1 = 27;
  localparam int LAT2 = 14;
`ifdef FDIV_ROUND_EN
  localparam logic [31:0] ONE_THIRD = 32'h3EAAAAAB;
`else
  localparam logic [31:0] ONE_THIRD = 32'h3EAAAAAA;
`endif

  always #5 clk = ~clk;

  fdiv_seq #(.BITS_PER_CYCLE(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x1(x1), .x2(x2), .out_valid(out_valid), .out_ready(out_ready), .y(y)
  );

  fdiv_seq #(.BITS_PER_CYCLE(2)) u_dut_b2 (
    .clk(clk), .rst(rst), .in_valid(in_valid_b2), .in_ready(in_ready_b2),
    .x1(x1_b2), .x2(x2_b2), .out_valid(out_valid_b2), .out_ready(out_ready_b2), .y(y_b2)
  );

  // Issue one operation and wait for out_valid; lat = -1 if never accepted, 100 on timeout.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit release_res,
                        output logic [31:0] res, output int lat);
    int t = 0;
    while (!in_ready && t < 100) begin @(posedge clk); #1; t++; end
    if (!in_ready) begin
      lat = -1;
      res = 32'hxxxxxxxx;
      return;
    end
    in_valid = 1'b1; x1 = a; x2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0; x1 = $urandom; x2 = $urandom;
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    res = y;
    if (release_res && out_valid) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x1 = 0; x2 = 0;
    in_valid_b2 = 1'b0; out_ready_b2 = 1'b0; x1_b2 = 0; x2_b2 = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    n_tests++;
    if (y !== 32'h0) begin n_fail++; $display("FAIL reset_y got=%h want=00000000", y); end
    $display("[TB] reset: out_valid=%b in_ready=%b y=%h", out_valid, in_ready, y);
  endtask

  task automatic test_vectors();
    logic [31:0] va [10], vb [10], vy [10];
    logic [31:0] res;
    int lat;
    va[0] = 32'h40C00000; vb[0] = 32'h40000000; vy[0] = 32'h40400000;
    va[1] = 32'h3F800000; vb[1] = 32'h40400000; vy[1] = ONE_THIRD;
    va[2] = 32'hC0F00000; vb[2] = 32'h40200000; vy[2] = 32'hC0400000;
    va[3] = 32'h3F800000; vb[3] = 32'h00000000; vy[3] = 32'h7F800000;
    va[4] = 32'hBF800000; vb[4] = 32'h00000000; vy[4] = 32'hFF800000;
    va[5] = 32'h00000000; vb[5] = 32'h40000000; vy[5] = 32'h00000000;
    va[6] = 32'h00000000; vb[6] = 32'h00000000; vy[6] = 32'h7F800000;
    va[7] = 32'h00800000; vb[7] = 32'h40000000; vy[7] = 32'h00000000;
    va[8] = 32'h7F000000; vb[8] = 32'h3F000000; vy[8] = 32'h7F800000;
    va[9] = 32'h7F7FFFFF; vb[9] = 32'h3F800000; vy[9] = 32'h7F7FFFFF;
    for (int i = 0; i < 10; i++) begin
      run_op(va[i], vb[i], 1'b1, res, lat);
      $display("[TB] vec%0d: %h / %h -> %h latency=%0d", i, va[i], vb[i], res, lat);
      n_tests++;
      if (res !== vy[i]) begin
        n_fail++; $display("FAIL vec%0d_y got=%h want=%h", i, res, vy[i]);
      end
      n_tests++;
      if (lat != LAT1) begin
        n_fail++; $display("FAIL vec%0d_latency got=%0d want=%0d", i, lat, LAT1);
      end
    end
  endtask

  task automatic test_latency_b2();
    int t = 0;
    int lat = 0;
    while (!in_ready_b2 && t < 100) begin @(posedge clk); #1; t++; end
    in_valid_b2 = 1'b1; x1_b2 = 32'h40C00000; x2_b2 = 32'h40000000;
    @(posedge clk); #1;
    in_valid_b2 = 1'b0; x1_b2 = $urandom; x2_b2 = $urandom;
    while (!out_valid_b2 && lat < 100) begin @(posedge clk); #1; lat++; end
    $display("[TB] b2: 40c00000 / 40000000 -> %h latency=%0d", y_b2, lat);
    n_tests++;
    if (lat != LAT2) begin n_fail++; $display("FAIL b2_latency got=%0d want=%0d", lat, LAT2); end
    n_tests++;
    if (y_b2 !== 32'h40400000) begin n_fail++; $display("FAIL b2_y got=%h want=40400000", y_b2); end
    out_ready_b2 = 1'b1;
    @(posedge clk); #1;
    out_ready_b2 = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] res;
    int lat;
    int bad = 0;
    run_op(32'h40C00000, 32'h40000000, 1'b0, res, lat);
    n_tests++;
    if (res !== 32'h40400000 || lat != LAT1) begin
      n_fail++; $display("FAIL bp_first y=%h lat=%0d want y=40400000 lat=%0d", res, lat, LAT1);
    end
    // Operands presented while DONE must be ignored.
    in_valid = 1'b1; x1 = 32'h3F800000; x2 = 32'h40400000;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({out_valid, in_ready, y} !== {1'b1, 1'b0, 32'h40400000}) begin
        n_fail++; bad++;
        $display("FAIL bp_hold%0d out_valid=%b in_ready=%b y=%h want 1 0 40400000",
                 i, out_valid, in_ready, y);
      end
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_tests++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL bp_release out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    $display("[TB] backpressure: held 10 cycles, bad=%0d, after release out_valid=%b in_ready=%b",
             bad, out_valid, in_ready);
  endtask

  task automatic test_back_to_back();
    logic [31:0] oa [4], ob [4], oy [4];
    int issued = 0;
    int got = 0;
    int extra = 0;
    bit acc;
    oa[0] = 32'h40C00000; ob[0] = 32'h40000000; oy[0] = 32'h40400000;
    oa[1] = 32'h3F800000; ob[1] = 32'h40400000; oy[1] = ONE_THIRD;
    oa[2] = 32'hC0F00000; ob[2] = 32'h40200000; oy[2] = 32'hC0400000;
    oa[3] = 32'h3F800000; ob[3] = 32'h00000000; oy[3] = 32'h7F800000;
    in_valid = 1'b1; x1 = oa[0]; x2 = ob[0]; out_ready = 1'b1;
    for (int c = 0; c < 400 && got < 4; c++) begin
      if (out_valid) begin
        $display("[TB] b2b result%0d: y=%h", got, y);
        n_tests++;
        if (y !== oy[got]) begin n_fail++; $display("FAIL b2b_y%0d got=%h want=%h", got, y, oy[got]); end
        got++;
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        issued++;
        if (issued < 4) begin x1 = oa[issued]; x2 = ob[issued]; end
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    n_tests++;
    if (got != 4) begin n_fail++; $display("FAIL b2b_count got=%0d want=4", got); end
    for (int c = 0; c < 40; c++) begin
      if (out_valid) extra++;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    n_tests++;
    if (extra != 0) begin n_fail++; $display("FAIL b2b_duplicate extra_valid_cycles=%0d want=0", extra); end
  endtask

  task automatic test_reset_mid_div();
    logic [31:0] res;
    int lat;
    int seen = 0;
    int t = 0;
    while (!in_ready && t < 100) begin @(posedge clk); #1; t++; end
    in_valid = 1'b1; x1 = 32'h3F800000; x2 = 32'h40400000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    $display("[TB] reset mid-DIV: out_valid=%b in_ready=%b y=%h", out_valid, in_ready, y);
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out_valid got=%b want=0", out_valid); end
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_in_ready got=%b want=1", in_ready); end
    n_tests++;
    if (y !== 32'h0) begin n_fail++; $display("FAIL rst_mid_y got=%h want=00000000", y); end
    for (int c = 0; c < 40; c++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    n_tests++;
    if (seen != 0) begin n_fail++; $display("FAIL rst_mid_stale valid_cycles=%0d want=0", seen); end
    run_op(32'h40C00000, 32'h40000000, 1'b1, res, lat);
    $display("[TB] post-reset: 40c00000 / 40000000 -> %h latency=%0d", res, lat);
    n_tests++;
    if (res !== 32'h40400000 || lat != LAT1) begin
      n_fail++; $display("FAIL rst_fresh got y=%h lat=%0d want y=40400000 lat=%0d", res, lat, LAT1);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_latency_b2();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_div();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
